// File: rtl/hog_pkg.sv
// Shared constants and FSM encoding for the HOG cell histogram accumulator.
package hog_pkg;
  localparam int CELL_ROWS  = 34;
  localparam int CELL_COLS  = 34;
  localparam int BINS       = 18;
  localparam int BANK_DEPTH = 5202;
  localparam int ADDR_W     = 13;
  localparam int NUM_BANKS  = 4;

  typedef enum logic [2:0] {
    IDLE, CLEAR, ACCEPT, RDWAIT, SUM, DONE
  } hog_state_t;
endpackage

// File: rtl/hog_cell_bin_accum_if.sv
// Pixel sample stream: frame start, valid/ready handshake and the sample payload.
interface hog_cell_bin_accum_if #(parameter int MAG_WIDTH = 16);
  logic                 start;
  logic                 pix_valid;
  logic                 pix_ready;
  logic                 pix_last;
  logic [5:0]           cell_row;
  logic [5:0]           cell_col;
  logic [4:0]           bin_idx;
  logic [MAG_WIDTH-1:0] mag;

  modport master (output start, pix_valid, pix_last, cell_row, cell_col, bin_idx, mag,
                  input  pix_ready);
  modport slave  (input  start, pix_valid, pix_last, cell_row, cell_col, bin_idx, mag,
                  output pix_ready);
endinterface

// File: rtl/hog_bin_addr_map.sv
// Maps (cell row, cell col, bin) onto one of four 2x2-interleaved banks and a word address.
module hog_bin_addr_map
  import hog_pkg::*;
(
  input  logic [5:0]        cell_row,
  input  logic [5:0]        cell_col,
  input  logic [4:0]        bin_idx,
  output logic [1:0]        bank,
  output logic [ADDR_W-1:0] addr,
  output logic              oor
);
  logic [ADDR_W-1:0] cell_idx;

  // even/even -> 3, even/odd -> 2, odd/even -> 1, odd/odd -> 0
  assign bank     = {~cell_row[0], ~cell_col[0]};
  assign cell_idx = ADDR_W'(cell_row[5:1]) * ADDR_W'(CELL_COLS / 2) + ADDR_W'(cell_col[5:1]);
  assign addr     = cell_idx * ADDR_W'(BINS) + ADDR_W'(bin_idx);
  assign oor      = (cell_row >= 6'(CELL_ROWS)) || (cell_col >= 6'(CELL_COLS)) ||
                    (bin_idx >= 5'(BINS));
endmodule

// File: rtl/hog_cell_bin_accum.sv
// Clears four histogram banks, then read-modify-writes one bin per accepted sample (3 cycles each).
module hog_cell_bin_accum
  import hog_pkg::*;
#(
  parameter int TOTAL_BIT_WIDTH = 35,
  parameter int MAG_WIDTH       = 16,
  parameter int DELAY           = 1
) (
  input  logic                       aclk,
  input  logic                       arest_n,
  hog_cell_bin_accum_if.slave        pix,
  output logic [ADDR_W-1:0]          bank_addr_0,
  output logic [ADDR_W-1:0]          bank_addr_1,
  output logic [ADDR_W-1:0]          bank_addr_2,
  output logic [ADDR_W-1:0]          bank_addr_3,
  output logic                       bank_we_0,
  output logic                       bank_we_1,
  output logic                       bank_we_2,
  output logic                       bank_we_3,
  output logic [TOTAL_BIT_WIDTH-1:0] bank_din_0,
  output logic [TOTAL_BIT_WIDTH-1:0] bank_din_1,
  output logic [TOTAL_BIT_WIDTH-1:0] bank_din_2,
  output logic [TOTAL_BIT_WIDTH-1:0] bank_din_3,
  input  logic [TOTAL_BIT_WIDTH-1:0] bank_dout_0,
  input  logic [TOTAL_BIT_WIDTH-1:0] bank_dout_1,
  input  logic [TOTAL_BIT_WIDTH-1:0] bank_dout_2,
  input  logic [TOTAL_BIT_WIDTH-1:0] bank_dout_3,
  output logic                       histogram_done,
  output logic                       busy,
  output logic                       err_range
);
  localparam int TW = TOTAL_BIT_WIDTH;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BANK_DEPTH - 1);

  // DELAY only shapes behavioural memory models; the RTL itself is zero-delay.
  if (DELAY < 0) begin : g_bad_delay
    $error("DELAY must be non-negative");
  end

  hog_state_t state, state_nxt;

  logic [NUM_BANKS-1:0][ADDR_W-1:0] addr_q;
  logic [NUM_BANKS-1:0]             we_q;
  logic [NUM_BANKS-1:0][TW-1:0]     din_q;
  logic [NUM_BANKS-1:0][TW-1:0]     dout;

  logic [1:0]           sel_q;
  logic [MAG_WIDTH-1:0] mag_q;
  logic                 last_q, oor_q;

  logic [1:0]        map_bank;
  logic [ADDR_W-1:0] map_addr;
  logic              map_oor;

  logic [TW:0]   sum;
  logic [TW-1:0] sat;

  hog_bin_addr_map u_map (
    .cell_row (pix.cell_row),
    .cell_col (pix.cell_col),
    .bin_idx  (pix.bin_idx),
    .bank     (map_bank),
    .addr     (map_addr),
    .oor      (map_oor)
  );

  assign dout = {bank_dout_3, bank_dout_2, bank_dout_1, bank_dout_0};
  assign {bank_addr_3, bank_addr_2, bank_addr_1, bank_addr_0} = addr_q;
  assign {bank_we_3, bank_we_2, bank_we_1, bank_we_0}         = we_q;
  assign {bank_din_3, bank_din_2, bank_din_1, bank_din_0}     = din_q;

  assign sum = {1'b0, dout[sel_q]} + (TW+1)'(mag_q);
  assign sat = sum[TW] ? '1 : sum[TW-1:0];

  assign pix.pix_ready   = (state == ACCEPT);
  assign busy            = (state != IDLE);
  assign histogram_done  = (state == DONE);

  always_ff @(posedge aclk or negedge arest_n) begin
    if (!arest_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pix.start) state_nxt = CLEAR;
      CLEAR:   if (addr_q[0] == LAST_ADDR) state_nxt = ACCEPT;
      ACCEPT:  if (pix.pix_valid) state_nxt = RDWAIT;
      RDWAIT:  state_nxt = SUM;
      SUM:     state_nxt = last_q ? DONE : ACCEPT;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered so the write lands one cycle after SUM, in ACCEPT or DONE.
  always_ff @(posedge aclk or negedge arest_n) begin
    if (!arest_n) begin
      addr_q    <= '0;
      we_q      <= '0;
      din_q     <= '0;
      err_range <= 1'b0;
      sel_q     <= '0;
      mag_q     <= '0;
      last_q    <= 1'b0;
      oor_q     <= 1'b0;
    end else begin
      we_q <= '0;
      case (state)
        IDLE: if (pix.start) begin
          addr_q    <= '0;
          we_q      <= '1;
          din_q     <= '0;
          err_range <= 1'b0;
        end
        CLEAR: if (addr_q[0] != LAST_ADDR) begin
          we_q <= '1;
          for (int b = 0; b < NUM_BANKS; b++) addr_q[b] <= addr_q[b] + 1'b1;
        end
        ACCEPT: if (pix.pix_valid) begin
          sel_q  <= map_bank;
          mag_q  <= pix.mag;
          last_q <= pix.pix_last;
          oor_q  <= map_oor;
          if (map_oor) err_range <= 1'b1;
          else         addr_q[map_bank] <= map_addr;
        end
        SUM: if (!oor_q) begin
          we_q[sel_q]  <= 1'b1;
          din_q[sel_q] <= sat;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_hog_cell_bin_accum.sv
// Directed bench: bank memory model, expected-write scoreboard and a negedge monitor.
module tb_hog_cell_bin_accum;
  import hog_pkg::*;

  localparam int TW = 35;
  localparam int MW = 16;

  typedef struct packed {
    logic [3:0]        we;
    logic [ADDR_W-1:0] addr;
    logic [TW-1:0]     din;
    logic              done;
  } exp_t;

  logic aclk = 1'b0;
  logic arest_n = 1'b0;
  always #5 aclk = ~aclk;

  hog_cell_bin_accum_if #(.MAG_WIDTH(MW)) pix();

  logic [ADDR_W-1:0] bank_addr_0, bank_addr_1, bank_addr_2, bank_addr_3;
  logic              bank_we_0, bank_we_1, bank_we_2, bank_we_3;
  logic [TW-1:0]     bank_din_0, bank_din_1, bank_din_2, bank_din_3;
  logic [TW-1:0]     bank_dout_0, bank_dout_1, bank_dout_2, bank_dout_3;
  logic              histogram_done, busy, err_range;

  hog_cell_bin_accum #(.TOTAL_BIT_WIDTH(TW), .MAG_WIDTH(MW), .DELAY(1)) dut (
    .aclk(aclk), .arest_n(arest_n), .pix(pix),
    .bank_addr_0(bank_addr_0), .bank_addr_1(bank_addr_1),
    .bank_addr_2(bank_addr_2), .bank_addr_3(bank_addr_3),
    .bank_we_0(bank_we_0), .bank_we_1(bank_we_1),
    .bank_we_2(bank_we_2), .bank_we_3(bank_we_3),
    .bank_din_0(bank_din_0), .bank_din_1(bank_din_1),
    .bank_din_2(bank_din_2), .bank_din_3(bank_din_3),
    .bank_dout_0(bank_dout_0), .bank_dout_1(bank_dout_1),
    .bank_dout_2(bank_dout_2), .bank_dout_3(bank_dout_3),
    .histogram_done(histogram_done), .busy(busy), .err_range(err_range)
  );

  logic [3:0]                we_v;
  logic [3:0][ADDR_W-1:0]    addr_v;
  logic [3:0][TW-1:0]        din_v;
  assign we_v   = {bank_we_3, bank_we_2, bank_we_1, bank_we_0};
  assign addr_v = {bank_addr_3, bank_addr_2, bank_addr_1, bank_addr_0};
  assign din_v  = {bank_din_3, bank_din_2, bank_din_1, bank_din_0};

  // Four synchronous-read banks, 1-cycle read latency, with a back-door preload port.
  logic [TW-1:0]     mem [4][BANK_DEPTH];
  logic              pre_en = 1'b0;
  logic [1:0]        pre_bank = '0;
  logic [ADDR_W-1:0] pre_addr = '0;
  logic [TW-1:0]     pre_data = '0;

  always @(posedge aclk) begin
    if (bank_we_0) mem[0][bank_addr_0] <= bank_din_0;
    if (bank_we_1) mem[1][bank_addr_1] <= bank_din_1;
    if (bank_we_2) mem[2][bank_addr_2] <= bank_din_2;
    if (bank_we_3) mem[3][bank_addr_3] <= bank_din_3;
    if (pre_en)    mem[pre_bank][pre_addr] <= pre_data;
    bank_dout_0 <= mem[0][bank_addr_0];
    bank_dout_1 <= mem[1][bank_addr_1];
    bank_dout_2 <= mem[2][bank_addr_2];
    bank_dout_3 <= mem[3][bank_addr_3];
  end

  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;
  exp_t   exp_q[$];

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  function automatic int bank_of(input logic [3:0] w);
    for (int i = 0; i < 4; i++) if (w[i]) return i;
    return 0;
  endfunction

  // Monitor: every non-clear write or done pulse must match the head of the queue.
  always @(negedge aclk) begin
    exp_t e;
    int   bi;
    if (arest_n && !(&we_v) && ((|we_v) || histogram_done)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_event", {59'd0, we_v, histogram_done}, 64'd0);
      end else begin
        e  = exp_q.pop_front();
        bi = bank_of(e.we);
        chk("sb_we", 64'(we_v), 64'(e.we));
        chk("sb_done", 64'(histogram_done), 64'(e.done));
        if (|e.we) begin
          chk("sb_addr", 64'(addr_v[bi]), 64'(e.addr));
          chk("sb_din", 64'(din_v[bi]), 64'(e.din));
        end
      end
    end
  end

  task automatic push(input logic [3:0] we, input int addr, input logic [TW-1:0] din, input bit done);
    exp_t e;
    e.we = we; e.addr = ADDR_W'(addr); e.din = din; e.done = done;
    exp_q.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge after the handshake edge.
  task automatic send(input int r, input int c, input int b, input int m, input bit last,
                      output longint hs);
    int n;
    pix.cell_row = 6'(r); pix.cell_col = 6'(c); pix.bin_idx = 5'(b);
    pix.mag = MW'(m); pix.pix_last = last; pix.pix_valid = 1'b1;
    n = 0;
    while (!pix.pix_ready && n < 100) begin @(negedge aclk); n++; end
    chk("pix_ready_wait", 64'(pix.pix_ready), 64'd1);
    @(posedge aclk);
    @(negedge aclk);
    hs = cyc;
    pix.pix_valid = 1'b0;
  endtask

  task automatic run_clear();
    int n, bad;
    pix.start = 1'b1;
    @(negedge aclk);
    pix.start = 1'b0;
    chk("clear_busy", 64'(busy), 64'd1);
    n = 0; bad = 0;
    while ((&we_v) && n < 6000) begin
      for (int i = 0; i < 4; i++)
        if (addr_v[i] != ADDR_W'(n) || din_v[i] != '0) bad++;
      n++;
      @(negedge aclk);
    end
    chk("clear_cycles", 64'(n), 64'd5202);
    chk("clear_addr_din_bad", 64'(bad), 64'd0);
    chk("clear_then_ready", 64'(pix.pix_ready), 64'd1);
    chk("clear_then_we", 64'(we_v), 64'd0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin @(negedge aclk); n++; end
    chk("busy_drop", 64'(busy), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    longint hs, hs0, hs1;
    int n;
    logic [TW-1:0] all1;
    all1 = '1;
    pix.start = 1'b0; pix.pix_valid = 1'b0; pix.pix_last = 1'b0;
    pix.cell_row = '0; pix.cell_col = '0; pix.bin_idx = '0; pix.mag = '0;

    repeat (3) @(negedge aclk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(pix.pix_ready), 64'd0);
    chk("rst_we", 64'(we_v), 64'd0);
    chk("rst_addr", 64'(addr_v), 64'd0);
    chk("rst_err", 64'(err_range), 64'd0);
    arest_n = 1'b1;
    @(negedge aclk);
    chk("idle_ready", 64'(pix.pix_ready), 64'd0);

    // Frame A: address map, accumulation, out-of-range gap, saturation
    run_clear();
    pre_en = 1'b1; pre_bank = 2'd1; pre_addr = ADDR_W'(310); pre_data = all1 - TW'(5);
    @(negedge aclk);
    pre_en = 1'b0;
    push(4'b0001, 35, TW'(7), 1'b0);     send(1, 3, 17, 7, 1'b0, hs);
    push(4'b0001, 5201, TW'(5), 1'b0);   send(33, 33, 17, 5, 1'b0, hs);
    push(4'b0100, 342, TW'(300), 1'b0);  send(2, 5, 0, 300, 1'b0, hs);
    push(4'b0001, 35, TW'(17), 1'b0);    send(1, 3, 17, 10, 1'b0, hs);
    send(0, 0, 18, 50, 1'b0, hs0);
    push(4'b1000, 668, TW'(1), 1'b0);    send(4, 6, 2, 1, 1'b0, hs1);
    chk("oor_next_gap", 64'(hs1 - hs0), 64'd3);
    chk("oor_err_set", 64'(err_range), 64'd1);
    push(4'b0010, 310, all1, 1'b1);      send(3, 0, 4, 10, 1'b1, hs);
    wait_idle();
    chk("err_sticky", 64'(err_range), 64'd1);

    // Frame B: new start clears err, start while busy ignored, single last sample
    run_clear();
    chk("start_clears_err", 64'(err_range), 64'd0);
    pix.start = 1'b1;
    @(negedge aclk);
    pix.start = 1'b0;
    @(negedge aclk);
    chk("busy_start_ready", 64'(pix.pix_ready), 64'd1);
    chk("busy_start_we", 64'(we_v), 64'd0);
    push(4'b1000, 9, TW'(100), 1'b1);    send(0, 0, 9, 100, 1'b1, hs);
    repeat (2) @(negedge aclk);
    chk("done_pulse", 64'(histogram_done), 64'd1);
    chk("done_busy", 64'(busy), 64'd1);
    @(negedge aclk);
    chk("busy_after_done", 64'(busy), 64'd0);
    chk("done_one_cycle", 64'(histogram_done), 64'd0);

    // Frame C: out-of-range last sample finishes without a write
    run_clear();
    push(4'b0000, 0, '0, 1'b1);          send(5, 40, 3, 9, 1'b1, hs);
    repeat (2) @(negedge aclk);
    chk("oor_last_done", 64'(histogram_done), 64'd1);
    chk("oor_last_nowe", 64'(we_v), 64'd0);
    @(negedge aclk);
    chk("oor_last_idle", 64'(busy), 64'd0);
    chk("oor_last_err", 64'(err_range), 64'd1);

    // Frame D: reset in the middle of CLEAR, then a fresh frame
    pix.start = 1'b1;
    @(negedge aclk);
    pix.start = 1'b0;
    n = 0;
    while (bank_addr_0 != ADDR_W'(1000) && n < 2000) begin @(negedge aclk); n++; end
    chk("clear_reach_1000", 64'(bank_addr_0), 64'd1000);
    #2 arest_n = 1'b0;
    #1;
    chk("midrst_we", 64'(we_v), 64'd0);
    chk("midrst_addr", 64'(addr_v), 64'd0);
    chk("midrst_din", 64'(|din_v), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_err", 64'(err_range), 64'd0);
    chk("midrst_ready_done", 64'({pix.pix_ready, histogram_done}), 64'd0);
    @(negedge aclk);
    arest_n = 1'b1;
    @(negedge aclk);
    run_clear();
    push(4'b1000, 668, TW'(2), 1'b1);    send(4, 6, 2, 2, 1'b1, hs);
    wait_idle();

    repeat (2) @(negedge aclk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
